// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Long ops take 33 edges (32 radix-2 steps in RUN, then sign fix-up in FIX).
// MTHI/MTLO write HI/LO in a single cycle while idle.
// Optional build macro MULDIV_FAST_MUL_EN: MULT/MULTU use a single-cycle
// 64-bit multiplier and finish one edge after acceptance; divides are unchanged.
module muldiv_unit #(
    parameter int unsigned      WIDTH   = 32,
    parameter logic [WIDTH-1:0] DIVZ_LO = '1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned DW = 2 * WIDTH;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [DW-1:0]    acc;     // MUL: {partial hi, multiplier/low}; DIV: {rem, quot}
    logic [WIDTH-1:0] opb;     // magnitude of B, or raw A on divide by zero
    logic             is_div;
    logic             divz;
    logic             neg_q;   // product / quotient needs negation
    logic             neg_r;   // remainder needs negation

    logic             op_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    logic [WIDTH:0]   mul_sum;
    logic [DW-1:0]    mul_next;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [DW-1:0]    div_next;
    logic [DW-1:0]    prod_fix;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    // Operand sign decode and magnitudes for signed ops
    always_comb begin
        op_signed = (op == OP_MULT) || (op == OP_DIV);
        a_neg     = op_signed & A[WIDTH-1];
        b_neg     = op_signed & B[WIDTH-1];
        mag_a     = a_neg ? (~A + WIDTH'(1)) : A;
        mag_b     = b_neg ? (~B + WIDTH'(1)) : B;
    end

    // One radix-2 step for each algorithm plus the final sign correction
    always_comb begin
        mul_sum  = {1'b0, acc[DW-1:WIDTH]} + (acc[0] ? {1'b0, opb} : (WIDTH+1)'(0));
        mul_next = {mul_sum, acc[WIDTH-1:1]};

        div_sh   = {acc[DW-1:WIDTH], acc[WIDTH-1]};
        div_ge   = (div_sh >= {1'b0, opb});
        div_diff = div_sh - {1'b0, opb};
        div_next = {(div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]),
                    acc[WIDTH-2:0], div_ge};

        prod_fix = neg_q ? (~acc + DW'(1)) : acc;
        quot_fix = neg_q ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0];
        rem_fix  = neg_r ? (~acc[DW-1:WIDTH] + WIDTH'(1)) : acc[DW-1:WIDTH];
    end

    // Control FSM, iteration datapath and HI/LO registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= S_IDLE;
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
            is_div <= 1'b0;
            divz   <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                acc    <= {WIDTH'(0), mag_a};
                                opb    <= mag_b;
                                is_div <= op[1];
                                divz   <= op[1] && (B == '0);
                                neg_q  <= a_neg ^ b_neg;
                                neg_r  <= a_neg;
                                cnt    <= '0;
                                busy   <= 1'b1;
                                state  <= S_RUN;
                                // Divide by zero returns the raw dividend in HI
                                if (op[1] && (B == '0)) begin
                                    opb <= A;
                                end
`ifdef MULDIV_FAST_MUL_EN
                                // Single-cycle multiply goes straight to fix-up
                                if (!op[1]) begin
                                    acc   <= DW'(mag_a) * DW'(mag_b);
                                    state <= S_FIX;
                                end
`endif
                            end
                            OP_MTHI: hi <= A;
                            OP_MTLO: lo <= A;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    if (!divz) begin
                        acc <= is_div ? div_next : mul_next;
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (is_div) begin
                        if (divz) begin
                            hi <= opb;
                            lo <= DIVZ_LO;
                        end else begin
                            hi <= rem_fix;
                            lo <= quot_fix;
                        end
                    end else begin
                        hi <= prod_fix[DW-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against an arithmetic reference.
module tb_muldiv_unit;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total;
    int bad;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    muldiv_unit dut (
        .clk   (clk),
        .rstn  (rstn),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference result {hi,lo} of a long op from plain arithmetic
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = '0;
        case (o)
            3'd0: res = 64'(sa * sb);
            3'd1: res = {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            3'd3: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else            res = {a % b, a / b};
            end
            default: res = {m_hi, m_lo};
        endcase
        return res;
    endfunction

    function automatic logic [31:0] pick_val();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'd0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = 32'($urandom_range(0, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Issue one op, wait for completion, and check timing and HI/LO
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input string tag, input bit inject);
        logic [63:0] exp;
        logic [31:0] old_hi;
        int          lat;
        int          n;
        old_hi = hi;
        lat = 33;
`ifdef MULDIV_FAST_MUL_EN
        if (o == 3'd0 || o == 3'd1) lat = 1;
`endif
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        op    = 3'($urandom_range(0, 7));
        if (o <= 3'd3) begin
            exp = model(o, a, b);
            check({tag, ".busy_e0"}, 32'(busy), 32'd1);
            n = 0;
            while (!done && n < 40) begin
                if (n == 5 && lat > 5) check({tag, ".hi_old"}, hi, old_hi);
                if (inject && n == 8) begin
                    start = 1'b1;
                    op    = 3'd0;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk);
                #1;
                n++;
            end
            start = 1'b0;
            check({tag, ".latency"}, 32'(n), 32'(lat));
            check({tag, ".busy_done"}, 32'(busy), 32'd0);
            check({tag, ".hi"}, hi, exp[63:32]);
            check({tag, ".lo"}, lo, exp[31:0]);
            m_hi = exp[63:32];
            m_lo = exp[31:0];
            @(posedge clk);
            #1;
            check({tag, ".done_pulse"}, 32'(done), 32'd0);
        end else begin
            if (o == 3'd4) m_hi = a;
            if (o == 3'd5) m_lo = a;
            check({tag, ".busy"}, 32'(busy), 32'd0);
            check({tag, ".done"}, 32'(done), 32'd0);
            check({tag, ".hi"}, hi, m_hi);
            check({tag, ".lo"}, lo, m_lo);
        end
    endtask

    initial begin
        int seen_done;
        logic [2:0] ro;
        clk   = 1'b0;
        rstn  = 1'b0;
        start = 1'b0;
        op    = 3'd0;
        A     = 32'd0;
        B     = 32'd0;
        total = 0;
        bad   = 0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        check("reset.hi", hi, 32'd0);
        check("reset.lo", lo, 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Load non-zero HI/LO, then abort a DIV with reset after E10
        run_op(3'd4, 32'hAAAA_5555, 32'd0, "pre_mthi", 1'b0);
        run_op(3'd5, 32'h5555_AAAA, 32'd0, "pre_mtlo", 1'b0);
        start = 1'b1;
        op    = 3'd2;
        A     = 32'd1000;
        B     = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        check("abort.hi", hi, 32'd0);
        check("abort.lo", lo, 32'd0);
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.done", 32'(done), 32'd0);
        @(posedge clk);
        #3;
        rstn = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
        end
        check("abort.no_done", 32'(seen_done), 32'd0);
        run_op(3'd0, 32'd6, 32'd7, "abort.mult_after", 1'b0);

        // Directed corner cases
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 1'b0);
        check("multu_max.hi_const", hi, 32'hFFFF_FFFE);
        check("multu_max.lo_const", lo, 32'h0000_0001);
        run_op(3'd0, 32'hFFFF_FFFD, 32'd7, "mult_neg", 1'b0);
        check("mult_neg.lo_const", lo, 32'hFFFF_FFEB);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div_neg", 1'b0);
        check("div_neg.lo_const", lo, 32'hFFFF_FFFD);
        check("div_neg.hi_const", hi, 32'hFFFF_FFFF);
        run_op(3'd3, 32'd7, 32'd2, "divu", 1'b0);
        check("divu.lo_const", lo, 32'd3);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b0);
        check("div_ovf.lo_const", lo, 32'h8000_0000);
        run_op(3'd3, 32'd5, 32'd0, "divu_z", 1'b0);
        check("divu_z.lo_const", lo, 32'hFFFF_FFFF);
        run_op(3'd2, 32'hFFFF_FFF0, 32'd0, "div_z", 1'b0);

        // MTHI, then a DIV with a MULT start pulsed while busy
        run_op(3'd4, 32'h0000_1234, 32'd0, "mthi", 1'b0);
        check("mthi.hi_const", hi, 32'h0000_1234);
        run_op(3'd2, 32'd100, 32'hFFFF_FFF9, "div_inject", 1'b1);
        run_op(3'd5, 32'hCAFE_F00D, 32'd0, "mtlo", 1'b0);
        run_op(3'd6, 32'h1111_1111, 32'd3, "op6", 1'b0);
        run_op(3'd7, 32'h2222_2222, 32'd3, "op7", 1'b0);

        // Randomized ops against the reference
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            run_op(ro, pick_val(), pick_val(), $sformatf("rnd%0d_op%0d", i, ro), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
